// File: rtl/lbp_stream_if.sv
// Pixel-fetch and LBP-write bus for lbp_stream.
// Optional macro LBP_THRESH_EN adds the lbp_thresh comparison offset.
// master: the LBP engine. slave: the gray/LBP memory side.
interface lbp_stream_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 14
);
    logic                  gray_ready;
    logic [DATA_WIDTH-1:0] gray_data;
    logic                  gray_req;
    logic [ADDR_WIDTH-1:0] gray_addr;
    logic                  lbp_valid;
    logic [ADDR_WIDTH-1:0] lbp_addr;
    logic [7:0]            lbp_data;
    logic                  finish;
`ifdef LBP_THRESH_EN
    logic [DATA_WIDTH-1:0] lbp_thresh;

    modport master (
        input  gray_ready, gray_data, lbp_thresh,
        output gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish
    );
    modport slave (
        output gray_ready, gray_data, lbp_thresh,
        input  gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish
    );
`else
    modport master (
        input  gray_ready, gray_data,
        output gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish
    );
    modport slave (
        output gray_ready, gray_data,
        input  gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish
    );
`endif
endinterface

// File: rtl/lbp_stream.sv
// Streaming 3x3 Local Binary Pattern engine: single raster pass over the
// gray image, two line buffers plus a window, one code per interior pixel.
// Optional macro LBP_THRESH_EN: neighbor >= center + lbp_thresh.
module lbp_stream #(
    parameter int unsigned IMG_W      = 128,
    parameter int unsigned IMG_H      = 128,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = $clog2(IMG_W * IMG_H)
) (
    input  logic clk,
    input  logic reset,
    lbp_stream_if.master bus
);
    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);
    localparam int unsigned CMP_W = DATA_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

    state_t                state_q, state_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] laddr_q, laddr_d;
    logic [7:0]            ldata_q, ldata_d;
    logic                  finish_q, finish_d;

    // Window columns: l* = column c-2, c* = column c-1 (t/m/b = rows r-2, r-1, r)
    logic [DATA_WIDTH-1:0] lt_q, lt_d, ct_q, ct_d;
    logic [DATA_WIDTH-1:0] lm_q, lm_d, cm_q, cm_d;
    logic [DATA_WIDTH-1:0] lb_q, lb_d, cb_q, cb_d;

    // line_a holds row r-2, line_b holds row r-1, both indexed by column
    logic [DATA_WIDTH-1:0] line_a_q [IMG_W];
    logic [DATA_WIDTH-1:0] line_b_q [IMG_W];

    logic                  consume;
    logic                  last_px;
    logic                  at_window;
    logic [DATA_WIDTH-1:0] top_px, mid_px, bot_px;
    logic [CMP_W-1:0]      ctr_cmp;
    logic [7:0]            code_c;

    function automatic logic ge(input logic [DATA_WIDTH-1:0] n,
                                input logic [CMP_W-1:0] c);
        return CMP_W'(n) >= c;
    endfunction

    assign consume      = (state_q == FETCH) && bus.gray_ready;
    assign bus.gray_req = consume;

    // Incoming column at the current fetch column and its LBP code
    always_comb begin
        top_px    = line_a_q[col_q];
        mid_px    = line_b_q[col_q];
        bot_px    = bus.gray_data;
        last_px   = (row_q == ROW_W'(IMG_H - 1)) && (col_q == COL_W'(IMG_W - 1));
        at_window = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
`ifdef LBP_THRESH_EN
        ctr_cmp   = CMP_W'(cm_q) + CMP_W'(bus.lbp_thresh);
`else
        ctr_cmp   = CMP_W'(cm_q);
`endif
        code_c[0] = ge(lt_q,   ctr_cmp);
        code_c[1] = ge(ct_q,   ctr_cmp);
        code_c[2] = ge(top_px, ctr_cmp);
        code_c[3] = ge(lm_q,   ctr_cmp);
        code_c[4] = ge(mid_px, ctr_cmp);
        code_c[5] = ge(lb_q,   ctr_cmp);
        code_c[6] = ge(cb_q,   ctr_cmp);
        code_c[7] = ge(bot_px, ctr_cmp);
    end

    // Next-state: FSM, raster counters, window shift and output strobe
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        addr_d   = addr_q;
        valid_d  = 1'b0;
        laddr_d  = laddr_q;
        ldata_d  = ldata_q;
        finish_d = 1'b0;
        lt_d = lt_q; ct_d = ct_q;
        lm_d = lm_q; cm_d = cm_q;
        lb_d = lb_q; cb_d = cb_q;
        case (state_q)
            IDLE: begin
                if (bus.gray_ready) state_d = FETCH;
            end
            FETCH: begin
                if (consume) begin
                    lt_d = ct_q; ct_d = top_px;
                    lm_d = cm_q; cm_d = mid_px;
                    lb_d = cb_q; cb_d = bot_px;
                    if (at_window) begin
                        valid_d = 1'b1;
                        laddr_d = addr_q - ADDR_WIDTH'(IMG_W + 1);
                        ldata_d = code_c;
                    end
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    if (col_q == COL_W'(IMG_W - 1)) begin
                        col_d = '0;
                        row_d = row_q + ROW_W'(1);
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                    if (last_px) begin
                        state_d  = DONE;
                        finish_d = 1'b1;
                        col_d    = '0;
                        row_d    = '0;
                        addr_d   = '0;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            col_q    <= '0;
            row_q    <= '0;
            addr_q   <= '0;
            valid_q  <= 1'b0;
            laddr_q  <= '0;
            ldata_q  <= '0;
            finish_q <= 1'b0;
            lt_q <= '0; ct_q <= '0;
            lm_q <= '0; cm_q <= '0;
            lb_q <= '0; cb_q <= '0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            addr_q   <= addr_d;
            valid_q  <= valid_d;
            laddr_q  <= laddr_d;
            ldata_q  <= ldata_d;
            finish_q <= finish_d;
            lt_q <= lt_d; ct_q <= ct_d;
            lm_q <= lm_d; cm_q <= cm_d;
            lb_q <= lb_d; cb_q <= cb_d;
        end
    end

    // Line buffers shift one row down per consumed pixel; contents never reset
    always_ff @(posedge clk) begin
        if (consume) begin
            line_a_q[col_q] <= mid_px;
            line_b_q[col_q] <= bot_px;
        end
    end

    assign bus.gray_addr = addr_q;
    assign bus.lbp_valid = valid_q;
    assign bus.lbp_addr  = laddr_q;
    assign bus.lbp_data  = ldata_q;
    assign bus.finish    = finish_q;
endmodule

// File: tb/tb_lbp_stream.sv
// Self-checking bench for lbp_stream at default 128x128 parameters.
module tb_lbp_stream;
    localparam int W  = 128;
    localparam int H  = 128;
    localparam int NP = W * H;

    typedef struct {
        int addr;
        int data;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lbp_stream_if #(.DATA_WIDTH(8), .ADDR_WIDTH(14)) bus ();

    lbp_stream #(.IMG_W(W), .IMG_H(H), .DATA_WIDTH(8), .ADDR_WIDTH(14)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   img [NP];
    int   obs [NP];
    ent_t exp_q [$];
    ent_t mon_e;

    int total = 0;
    int bad   = 0;

    int cycle = 0;
    int fetch_idx = 0;
    int nvalid, nfinish, first_addr, last_addr;
    int first_req_cyc, first_val_cyc;
    int prev_addr = 0, prev_data = 0;
    bit prev_reset = 1'b1;

    assign bus.gray_data = 8'(img[bus.gray_addr]);
`ifdef LBP_THRESH_EN
    assign bus.lbp_thresh = 8'd0;
`endif

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Code for center (r,c) of a w-wide image straight from the bit-map rule
    function automatic int lbp_at(input int w, input int r, input int c, input int thr);
        int dr [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
        int dc [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
        int code = 0;
        for (int b = 0; b < 8; b++)
            if (img[(r + dr[b]) * w + c + dc[b]] >= img[r * w + c] + thr)
                code |= (1 << b);
        return code;
    endfunction

    task automatic build_expected(input int w, input int h, input int thr);
        ent_t e;
        exp_q.delete();
        for (int r = 1; r < h - 1; r++)
            for (int c = 1; c < w - 1; c++) begin
                e.addr = r * w + c;
                e.data = lbp_at(w, r, c, thr);
                exp_q.push_back(e);
            end
    endtask

    // Compare process: sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        cycle++;
        if (bus.gray_req) begin
            chk("fetch_addr", int'(bus.gray_addr), fetch_idx);
            if (fetch_idx == 0) first_req_cyc = cycle;
            fetch_idx++;
        end
        if (!bus.gray_ready) chk("req_during_stall", int'(bus.gray_req), 0);
        if (bus.lbp_valid) begin
            if (exp_q.size() == 0) begin
                chk("extra_write", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("lbp_addr", int'(bus.lbp_addr), mon_e.addr);
                chk("lbp_data", int'(bus.lbp_data), mon_e.data);
            end
            obs[bus.lbp_addr] = int'(bus.lbp_data);
            if (nvalid == 0) begin
                first_addr    = int'(bus.lbp_addr);
                first_val_cyc = cycle;
            end
            last_addr = int'(bus.lbp_addr);
            nvalid++;
        end else if (!prev_reset && !reset) begin
            chk("hold_addr", int'(bus.lbp_addr), prev_addr);
            chk("hold_data", int'(bus.lbp_data), prev_data);
        end
        if (bus.finish) begin
            nfinish++;
            chk("finish_with_last_write", int'(bus.lbp_valid), 1);
            chk("finish_queue_empty", exp_q.size(), 0);
        end
        prev_addr  = int'(bus.lbp_addr);
        prev_data  = int'(bus.lbp_data);
        prev_reset = reset;
    end

    task automatic clear_stats();
        nvalid = 0; nfinish = 0; fetch_idx = 0;
        first_addr = -1; last_addr = -1;
        first_req_cyc = 0; first_val_cyc = 0;
    endtask

    // Runs one frame; stall_pct random stalls, fixed adds the 10/3-cycle stalls
    task automatic run_frame(input int stall_pct, input bit fixed, input bit lat);
        int cyc = 0;
        int stall_left = 0;
        bit s1 = 1'b0, s2 = 1'b0;
        build_expected(W, H, 0);
        clear_stats();
        @(posedge clk); #1 bus.gray_ready = 1'b1;
        while (nfinish == 0 && cyc < 40000) begin
            @(posedge clk); #1;
            if (nfinish != 0) begin
                bus.gray_ready = 1'b0;
            end else if (stall_left > 0) begin
                bus.gray_ready = 1'b0;
                stall_left--;
            end else if (fixed && fetch_idx == 1000 && !s1) begin
                s1 = 1'b1; stall_left = 9; bus.gray_ready = 1'b0;
            end else if (fixed && fetch_idx == 5000 && !s2) begin
                s2 = 1'b1; stall_left = 2; bus.gray_ready = 1'b0;
            end else begin
                bus.gray_ready = ($urandom_range(99) >= stall_pct);
            end
            cyc++;
        end
        chk("frame_timeout", int'(cyc < 40000), 1);
        bus.gray_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("finish_pulses", nfinish, 1);
        chk("write_count", nvalid, 15876);
        chk("first_write_addr", first_addr, 129);
        chk("last_write_addr", last_addr, 16254);
        chk("queue_drained", exp_q.size(), 0);
        if (lat) chk("first_write_latency", first_val_cyc - first_req_cyc, 2 * W + 3);
    endtask

    initial begin
        int cyc;
        reset = 1'b1;
        bus.gray_ready = 1'b0;
        clear_stats();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gray_req", int'(bus.gray_req), 0);
        chk("rst_gray_addr", int'(bus.gray_addr), 0);
        chk("rst_lbp_valid", int'(bus.lbp_valid), 0);
        chk("rst_lbp_addr", int'(bus.lbp_addr), 0);
        chk("rst_lbp_data", int'(bus.lbp_data), 0);
        chk("rst_finish", int'(bus.finish), 0);
        @(posedge clk); #1 reset = 1'b0;

        // Model pins: 8x8 gray=addr frame
        for (int i = 0; i < 64; i++) img[i] = i;
        chk("model_8x8_thr0", lbp_at(8, 1, 1, 0), 8'hF0);
        chk("model_8x8_thr5", lbp_at(8, 1, 1, 5), 8'hE0);
        build_expected(8, 8, 0);
        chk("model_8x8_count", exp_q.size(), 36);
        chk("model_8x8_first", exp_q[0].addr, 9);
        chk("model_8x8_last", exp_q[35].data, 8'hF0);
        exp_q.delete();

        // Frame 1: flat image
        for (int i = 0; i < NP; i++) img[i] = 50;
        build_expected(W, H, 0);
        chk("model_flat_code", exp_q[100].data, 8'hFF);
        run_frame(0, 1'b0, 1'b1);

        // Frame 2: single bright pixel at (5,5)
        for (int i = 0; i < NP; i++) img[i] = 0;
        img[645] = 200;
        build_expected(W, H, 0);
        chk("model_spot_addr", exp_q[508].addr, 645);
        chk("model_spot_code", exp_q[508].data, 8'h00);
        run_frame(0, 1'b0, 1'b1);
        chk("spot_center", obs[645], 8'h00);
        chk("spot_neighbor", obs[644], 8'hFF);
        chk("spot_far", obs[1000], 8'hFF);

        // Frame 3: gray = addr, fixed stalls plus sparse random ones
        for (int i = 0; i < NP; i++) img[i] = i & 255;
        run_frame(2, 1'b1, 1'b0);

        // Reset mid-frame at fetch index 1000
        for (int i = 0; i < NP; i++) img[i] = int'($urandom_range(255));
        build_expected(W, H, 0);
        clear_stats();
        @(posedge clk); #1 bus.gray_ready = 1'b1;
        cyc = 0;
        while (fetch_idx < 1000 && cyc < 5000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("reset_reach_timeout", int'(cyc < 5000), 1);
        reset = 1'b1;
        bus.gray_ready = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_gray_req", int'(bus.gray_req), 0);
        chk("mid_rst_gray_addr", int'(bus.gray_addr), 0);
        chk("mid_rst_lbp_valid", int'(bus.lbp_valid), 0);
        chk("mid_rst_lbp_addr", int'(bus.lbp_addr), 0);
        chk("mid_rst_lbp_data", int'(bus.lbp_data), 0);
        chk("mid_rst_finish", int'(bus.finish), 0);
        exp_q.delete();

        // Frame 4: random pixels after reset, random stalls
        for (int i = 0; i < NP; i++) img[i] = int'($urandom_range(255));
        run_frame(5, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
